in_dispatch_network: RTL and testbench

- Inbound counterpart of the matcher output-collection network.
- Accepts one stream of 10-bit tag words from the upstream parser (valid/ready) and distributes them round-robin across ncount matchers.
- Each lane has its own small FIFO, so a stalled matcher does not block the others.
- Sits between the tag source and the matcher array; matchers pop words with a per-lane valid/ack handshake.

---
 rtl/in_net_pkg.sv | 34 +++
 rtl/in_lane_fifo.sv | 68 ++++++
 rtl/in_dispatch_network.sv | 65 ++++++
 tb/tb_in_dispatch_network.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/in_net_pkg.sv
// Shared types and the round-robin lane picker for the inbound dispatch network.
package in_net_pkg;
  localparam int WIDTH     = 10;
  localparam int MAX_LANES = 32;
  localparam int LANE_W    = 5;

  typedef logic [WIDTH-1:0]  tag_t;
  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [LANE_W:0]   lane_ext_t;

  typedef struct packed {
    logic  found;
    lane_t idx;
  } rr_sel_t;

  // First non-full lane scanning upward from rr, wrapping at n.
  function automatic rr_sel_t rr_select(input logic [MAX_LANES-1:0] full_vec,
                                        input lane_t rr, input int n);
    rr_sel_t   r;
    lane_ext_t j;
    r = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < n) begin
        j = {1'b0, rr} + lane_ext_t'(k);
        if (j >= lane_ext_t'(n)) j = j - lane_ext_t'(n);
        if (!r.found && !full_vec[j[LANE_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[LANE_W-1:0];
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/in_lane_fifo.sv
// Per-lane FIFO with registered flags and a registered head word that holds
// its last value once the lane drains.
module in_lane_fifo #(
  parameter int width = 10,
  parameter int depth = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [width-1:0] q,
  output logic             empty,
  output logic             full
);
  localparam int          AW       = $clog2(depth);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(depth);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             r_empty, r_full;
  logic [width-1:0] r_q;

  logic             w_wr, w_rd;
  logic [AW-1:0]    w_rp1;
  logic [AW:0]      w_cnt_nxt;

  assign w_wr  = wrreq & ~r_full;
  assign w_rd  = rdreq & ~r_empty;
  assign w_rp1 = r_rp + AW'(1);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr && !w_rd)      w_cnt_nxt = r_cnt + CNT_ONE;
    else if (w_rd && !w_wr) w_cnt_nxt = r_cnt - CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wp] <= data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_q     <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= w_rp1;
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CNT_FULL);
      // Head reloads from the incoming word when it lands at the front,
      // otherwise from the next stored entry; a pop to empty holds it.
      if (w_wr && (r_empty || (w_rd && r_cnt == CNT_ONE))) r_q <= data;
      else if (w_rd && r_cnt > CNT_ONE)                      r_q <= r_mem[w_rp1];
    end
  end

  assign q     = r_q;
  assign empty = r_empty;
  assign full  = r_full;
endmodule

// File: rtl/in_dispatch_network.sv
// Round-robin dispatch of one tag stream across ncount independent lane FIFOs.
module in_dispatch_network
  import in_net_pkg::*;
#(
  parameter int ncount = 8,
  parameter int depth  = 4,
  parameter int width  = WIDTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [width-1:0]  tag_data,
  input  logic              tag_valid,
  output logic              tag_ready,
  output logic [width-1:0]  datain [ncount-1:0],
  output logic [ncount-1:0] din_valid,
  input  logic [ncount-1:0] din_ack,
  output logic [15:0]       words_in,
  output logic              idle
);
  logic [ncount-1:0]    w_full, w_empty, w_wr;
  logic [MAX_LANES-1:0] w_full_ext;
  rr_sel_t              w_sel;
  lane_t                w_nxt;
  logic                 w_acc;
  lane_t                r_rr;
  logic [15:0]          r_words;

  always_comb begin
    w_full_ext             = '0;
    w_full_ext[ncount-1:0] = w_full;
    w_sel                  = rr_select(w_full_ext, r_rr, ncount);
  end

  assign tag_ready = resetn & w_sel.found;
  assign w_acc     = tag_valid & tag_ready;
  assign w_nxt     = (w_sel.idx == lane_t'(ncount-1)) ? '0 : w_sel.idx + lane_t'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rr    <= '0;
      r_words <= '0;
    end else if (w_acc) begin
      r_rr    <= w_nxt;
      r_words <= r_words + 16'd1;
    end
  end

  for (genvar g = 0; g < ncount; g++) begin : g_lane
    assign w_wr[g] = w_acc && (w_sel.idx == lane_t'(g));
    in_lane_fifo #(.width(width), .depth(depth)) u_lane (
      .clock  (clock),
      .resetn (resetn),
      .data   (tag_data),
      .wrreq  (w_wr[g]),
      .rdreq  (din_ack[g]),
      .q      (datain[g]),
      .empty  (w_empty[g]),
      .full   (w_full[g])
    );
  end

  assign din_valid = ~w_empty;
  assign idle      = &w_empty;
  assign words_in  = r_words;
endmodule

// File: tb/tb_in_dispatch_network.sv
// Directed bench with a queue-per-lane reference model checked every cycle.
module tb_in_dispatch_network;
  localparam int NC = 4, DP = 2, W = 10;

  logic          clock = 1'b0;
  logic          resetn;
  logic [W-1:0]  tag_data;
  logic          tag_valid, tag_ready;
  logic [W-1:0]  datain [NC-1:0];
  logic [NC-1:0] din_valid, din_ack;
  logic [15:0]   words_in;
  logic          idle;

  in_dispatch_network #(.ncount(NC), .depth(DP), .width(W)) dut (
    .clock(clock), .resetn(resetn), .tag_data(tag_data), .tag_valid(tag_valid),
    .tag_ready(tag_ready), .datain(datain), .din_valid(din_valid),
    .din_ack(din_ack), .words_in(words_in), .idle(idle));

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0, dut_pops = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0h want %0h", nm, idx, $time, act, exp);
  endtask

  // Reference model: one queue per lane, round-robin pointer, word counter.
  logic [W-1:0] mq [NC][$];
  logic [W-1:0] mlast [NC];
  int           m_rr;
  logic [15:0]  m_words;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NC; i++) begin mq[i].delete(); mlast[i] = '0; end
      m_rr = 0; m_words = '0;
    end else begin
      int s; bit f; int j;
      s = 0; f = 0;
      for (int k = 0; k < NC; k++) begin
        j = (m_rr + k) % NC;
        if (!f && mq[j].size() < DP) begin s = j; f = 1; end
      end
      for (int i = 0; i < NC; i++)
        if (din_ack[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (tag_valid && f) begin
        mq[s].push_back(tag_data);
        m_rr = (s + 1) % NC;
        m_words = m_words + 16'd1;
      end
      for (int i = 0; i < NC; i++) if (mq[i].size() > 0) mlast[i] = mq[i][0];
    end
  end

  always @(negedge clock) begin
    bit anyfree, allempty;
    anyfree = 0; allempty = 1;
    for (int i = 0; i < NC; i++) begin
      if (mq[i].size() < DP) anyfree = 1;
      if (mq[i].size() > 0) allempty = 0;
    end
    chk("tag_ready", 0, 32'(tag_ready), 32'(resetn && anyfree));
    for (int i = 0; i < NC; i++) begin
      chk("din_valid", i, 32'(din_valid[i]), 32'(mq[i].size() > 0));
      chk("datain", i, 32'(datain[i]), 32'(mlast[i]));
      if (din_ack[i] && din_valid[i]) dut_pops++;
    end
    chk("words_in", 0, 32'(words_in), 32'(m_words));
    chk("idle", 0, 32'(idle), 32'(allempty));
  end

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic [NC-1:0] ack);
    tag_valid = v; tag_data = d; din_ack = ack;
    @(posedge clock); #1;
  endtask

  // Asynchronous reset pulse placed between edges, checked before any clock edge.
  task automatic pulse_reset();
    #1 resetn = 1'b0;
    #1;
    chk("rst_din_valid", 0, 32'(din_valid), 32'h0);
    chk("rst_tag_ready", 0, 32'(tag_ready), 32'h0);
    chk("rst_idle", 0, 32'(idle), 32'h1);
    chk("rst_words_in", 0, 32'(words_in), 32'h0);
    chk("rst_datain", 0, 32'(datain[0]), 32'h0);
    #1 resetn = 1'b1;
    #1;
    chk("rel_tag_ready", 0, 32'(tag_ready), 32'h1);
  endtask

  int p0;

  initial begin
    resetn = 1'b1; tag_valid = 1'b0; tag_data = '0; din_ack = '0;
    #2 resetn = 1'b0;
    @(posedge clock); #1;
    chk("init_tag_ready", 0, 32'(tag_ready), 32'h0);
    chk("init_idle", 0, 32'(idle), 32'h1);
    resetn = 1'b1;

    // Fill all lanes, overflow attempt, then free lane 2 and refill it.
    pulse_reset();
    for (int i = 1; i <= 8; i++) cyc(1'b1, W'(i), '0);
    chk("t1_ready", 0, 32'(tag_ready), 32'h0);
    chk("t1_words", 0, 32'(words_in), 32'd8);
    chk("t1_idle", 0, 32'(idle), 32'h0);
    for (int i = 0; i < NC; i++) chk("t1_head", i, 32'(datain[i]), 32'(i + 1));
    cyc(1'b1, 10'h009, '0);
    chk("t1_words9", 0, 32'(words_in), 32'd8);
    cyc(1'b1, 10'h009, 4'b0100);
    chk("t3_ready", 0, 32'(tag_ready), 32'h1);
    chk("t3_head2", 0, 32'(datain[2]), 32'h7);
    cyc(1'b1, 10'h009, '0);
    chk("t3_words", 0, 32'(words_in), 32'd9);
    chk("t3_full", 0, 32'(tag_ready), 32'h0);
    cyc(1'b0, '0, 4'b0100);
    chk("t3_lane2", 0, 32'(datain[2]), 32'h9);

    // Lane 1 kept full, the rest drained; stream skips lane 1.
    pulse_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, W'(10'h020 + i), '0);
    cyc(1'b0, '0, 4'b1101);
    cyc(1'b0, '0, 4'b1101);
    chk("t2_valid", 0, 32'(din_valid), 32'b0010);
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(10'h010 + i), '0);
    chk("t2_l0", 0, 32'(datain[0]), 32'h010);
    chk("t2_l1", 0, 32'(datain[1]), 32'h021);
    chk("t2_l2", 0, 32'(datain[2]), 32'h011);
    chk("t2_l3", 0, 32'(datain[3]), 32'h012);
    cyc(1'b1, 10'h013, '0);
    cyc(1'b0, '0, 4'b0001);
    chk("t2_rr0", 0, 32'(datain[0]), 32'h013);

    // Push into empty lane with ack, then push+pop on a one-entry lane.
    pulse_reset();
    cyc(1'b1, 10'h0AA, 4'b0001);
    chk("t4_empty_ack", 0, 32'(datain[0]), 32'h0AA);
    chk("t4_valid0", 0, 32'(din_valid[0]), 32'h1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, W'(i), '0);
    cyc(1'b1, 10'h0BB, 4'b0001);
    chk("t4_bb", 0, 32'(datain[0]), 32'h0BB);
    chk("t4_words", 0, 32'(words_in), 32'd5);
    cyc(1'b0, '0, 4'b0001);
    chk("t4_occ1", 0, 32'(din_valid[0]), 32'h0);
    chk("t4_hold", 0, 32'(datain[0]), 32'h0BB);

    // Mid-stream reset with lanes half full.
    pulse_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(10'h031 + i), '0);
    pulse_reset();

    // Counter wrap with continuous acks.
    p0 = dut_pops;
    for (int i = 0; i < 65537; i++) cyc(1'b1, W'(i), '1);
    cyc(1'b0, '0, '1);
    cyc(1'b0, '0, '1);
    chk("wrap_words", 0, 32'(words_in), 32'h0001);
    chk("wrap_pops", 0, 32'(dut_pops - p0), 32'd65537);
    chk("wrap_idle", 0, 32'(idle), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
